// File: rtl/q_stream_monitor.sv
// +--------------------------------------------------------------------------+
// | q_stream_monitor: serial pattern detector with saturating edge counters   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module q_stream_monitor #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             last_bit
);

  localparam int               c_FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_LEN);
  localparam logic [c_FILL_W-1:0] c_FILL_ARM = c_FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  // Only the newest PAT_LEN-1 history bits are retained; the oldest bit of
  // the window would be shifted out by the very sample that completes it.
  logic [PAT_LEN-2:0]  r_hist;
  logic [c_FILL_W-1:0] r_fill;
  logic                r_have_prev;

  logic [PAT_LEN-1:0]  w_window;
  logic                w_match;
  logic                w_rise;
  logic                w_fall;

  always_comb begin
    w_window = {r_hist, din};
    w_match  = din_valid && (r_fill >= c_FILL_ARM) && (w_window == PATTERN);
    w_rise   = din_valid && r_have_prev && !last_bit &&  din;
    w_fall   = din_valid && r_have_prev &&  last_bit && !din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist      <= '0;
      r_fill      <= '0;
      r_have_prev <= 1'b0;
      last_bit    <= 1'b0;
      detect      <= 1'b0;
      match_cnt   <= '0;
      rise_cnt    <= '0;
      fall_cnt    <= '0;
    end else begin
      detect <= w_match;

      if (din_valid) begin
        r_hist      <= w_window[PAT_LEN-2:0];
        r_have_prev <= 1'b1;
        last_bit    <= din;
        if (r_fill != c_FILL_MAX) begin
          r_fill <= r_fill + c_FILL_W'(1);
        end
      end

      // Clear beats any increment landing in the same cycle.
      if (clear) begin
        match_cnt <= '0;
        rise_cnt  <= '0;
        fall_cnt  <= '0;
      end else begin
        if (w_match && (match_cnt != c_CNT_MAX)) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
        if (w_rise && (rise_cnt != c_CNT_MAX)) begin
          rise_cnt <= rise_cnt + CNT_W'(1);
        end
        if (w_fall && (fall_cnt != c_CNT_MAX)) begin
          fall_cnt <= fall_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_q_stream_monitor.sv
// +--------------------------------------------------------------------------+
// | tb_q_stream_monitor: directed + random bench with a sample-list model     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_q_stream_monitor;

  localparam int             PAT_LEN = 4;
  localparam logic [3:0]     PAT     = 4'b1011;
  localparam int             MAX_A   = 255;
  localparam int             MAX_B   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       clear = 1'b0;

  logic       det_a, last_a, det_b, last_b;
  logic [7:0] mc_a, rc_a, fc_a;
  logic [1:0] mc_b, rc_b, fc_b;

  int vectors = 0;
  int errors  = 0;

  // Reference state: list of valid samples since reset and plain counters.
  bit samp[$];
  bit m_det, m_last, m_have_prev;
  int m_match_a, m_rise_a, m_fall_a;
  int m_match_b, m_rise_b, m_fall_b;

  q_stream_monitor #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .detect(det_a), .match_cnt(mc_a), .rise_cnt(rc_a), .fall_cnt(fc_a),
    .last_bit(last_a)
  );

  q_stream_monitor #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .detect(det_b), .match_cnt(mc_b), .rise_cnt(rc_b), .fall_cnt(fc_b),
    .last_bit(last_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_match(input bit d);
    int n;
    n = samp.size();
    if (n + 1 < PAT_LEN) return 1'b0;
    for (int i = 0; i < PAT_LEN - 1; i++) begin
      if (samp[n - (PAT_LEN - 1) + i] != PAT[PAT_LEN - 1 - i]) return 1'b0;
    end
    return d == PAT[0];
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_update(input bit r, input bit v, input bit d, input bit c);
    bit rs, fl;
    if (r) begin
      samp.delete();
      m_det = 0; m_last = 0; m_have_prev = 0;
      m_match_a = 0; m_rise_a = 0; m_fall_a = 0;
      m_match_b = 0; m_rise_b = 0; m_fall_b = 0;
      return;
    end
    m_det = v && model_match(d);
    rs = v && m_have_prev && !m_last && d;
    fl = v && m_have_prev && m_last && !d;
    if (v) begin
      samp.push_back(d);
      if (samp.size() > PAT_LEN) void'(samp.pop_front());
      m_last = d;
      m_have_prev = 1;
    end
    if (c) begin
      m_match_a = 0; m_rise_a = 0; m_fall_a = 0;
      m_match_b = 0; m_rise_b = 0; m_fall_b = 0;
    end else begin
      if (m_det) begin m_match_a = sat_inc(m_match_a, MAX_A); m_match_b = sat_inc(m_match_b, MAX_B); end
      if (rs)    begin m_rise_a  = sat_inc(m_rise_a,  MAX_A); m_rise_b  = sat_inc(m_rise_b,  MAX_B); end
      if (fl)    begin m_fall_a  = sat_inc(m_fall_a,  MAX_A); m_fall_b  = sat_inc(m_fall_b,  MAX_B); end
    end
  endtask

  // Apply one cycle of inputs, then compare both instances to the model.
  task automatic step(input bit r, input bit v, input bit d, input bit c);
    reset = r; din_valid = v; din = d; clear = c;
    @(posedge clk);
    #1;
    model_update(r, v, d, c);
    chk("detect_a",   int'(det_a),  int'(m_det));
    chk("match_a",    int'(mc_a),   m_match_a);
    chk("rise_a",     int'(rc_a),   m_rise_a);
    chk("fall_a",     int'(fc_a),   m_fall_a);
    chk("last_a",     int'(last_a), int'(m_last));
    chk("detect_b",   int'(det_b),  int'(m_det));
    chk("match_b",    int'(mc_b),   m_match_b);
    chk("rise_b",     int'(rc_b),   m_rise_b);
    chk("fall_b",     int'(fc_b),   m_fall_b);
    chk("last_b",     int'(last_b), int'(m_last));
  endtask

  task automatic feed(input bit d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    bit s7[7];
    s7 = '{1, 0, 1, 1, 0, 1, 1};

    // Reset held two cycles against a live valid stream.
    step(1, 1, 1, 0);
    chk("rst_detect", int'(det_a), 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("post_rst_match", int'(mc_a), 0);
    chk("post_rst_last",  int'(last_a), 0);

    // Overlapping pattern plus edges.
    for (int i = 0; i < 7; i++) begin
      feed(s7[i]);
      if (i == 3 || i == 6) chk("s7_detect_hi", int'(det_a), 1);
      else                  chk("s7_detect_lo", int'(det_a), 0);
    end
    chk("s7_match", int'(mc_a), 2);
    chk("s7_rise",  int'(rc_a), 2);
    chk("s7_fall",  int'(fc_a), 2);
    chk("s7_last",  int'(last_a), 1);

    // Same pattern with three-cycle invalid gaps and noisy din.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      feed(s7[i]);
      chk("gap_detect", int'(det_a), (i == 3) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        step(0, 0, 1'($urandom_range(0, 1)), 0);
        chk("gap_idle_detect", int'(det_a), 0);
      end
    end
    chk("gap_match", int'(mc_a), 1);
    chk("gap_rise",  int'(rc_a), 1);
    chk("gap_fall",  int'(fc_a), 1);

    // Saturation on the narrow instance.
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) feed(1'(i % 2));
    chk("sat_rise_b", int'(rc_b), 3);
    chk("sat_fall_b", int'(fc_b), 3);
    chk("sat_rise_a", int'(rc_a), 6);
    chk("sat_fall_a", int'(fc_a), 5);

    // Reset mid-pattern discards the partial window.
    step(1, 0, 0, 0);
    feed(1); feed(0); feed(1);
    step(1, 1, 1, 0);
    feed(1);
    chk("midrst_no_det", int'(det_a), 0);
    feed(0); feed(1);
    chk("midrst_no_det2", int'(det_a), 0);
    feed(1);
    chk("midrst_det", int'(det_a), 1);

    // Clear colliding with a completing match.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) feed(s7[i]);
    chk("clr_pre_match", int'(mc_a), 1);
    feed(0); feed(1);
    step(0, 1, 1, 1);
    chk("clr_detect", int'(det_a), 1);
    chk("clr_match",  int'(mc_a), 0);
    chk("clr_rise",   int'(rc_a), 0);
    chk("clr_fall",   int'(fc_a), 0);
    feed(0); feed(1); feed(1);
    chk("clr_after_match", int'(mc_a), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 1),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
